sw_debounce8: RTL and testbench

- Input-conditioning stage that sits directly upstream of the 8-3 priority encoder / 7-seg path.
- Takes raw, bouncy board switches (8 data switches plus one enable switch) and synchronises each into clk.
- Debounces every channel independently with a stability counter.
- Drives clean, glitch-free x/en vectors to the encoder, plus a one-cycle change strobe for downstream logging/display refresh.

---
 rtl/sw_debounce8.sv | 108 ++++++++++
 tb/tb_sw_debounce8.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce8.sv
// sw_debounce8: input conditioning for raw board switches ahead of the
// 8-3 priority encoder / 7-seg path.
//
// Each of NBIT+1 channels (sw_in[NBIT-1:0], en_in) is synchronised through a
// two-flop synchroniser. It is then debounced by a per-channel stability
// counter. A new level is accepted only after STABLE_CYC consecutive
// mismatching cycles.
//
// Ports:
//   clk     system clock, all state on rising edge
//   rst     asynchronous active-high reset
//   sw_in   raw data switches (asynchronous)
//   en_in   raw enable switch (asynchronous)
//   x_out   debounced data switches (registered)
//   en_out  debounced enable (registered)
//   chg     one-cycle pulse in the cycle a debounced bit updates
//
// Build option: define SWDB_CHG_PULSE_EN to build the chg strobe. When it is
// undefined, chg is tied to 0 and x_out/en_out behave identically.

module sw_debounce8 #(
    parameter int unsigned NBIT       = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned STABLE_CYC = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBIT-1:0] sw_in,
    input  logic            en_in,
    output logic [NBIT-1:0] x_out,
    output logic            en_out,
    output logic            chg
);

    localparam int unsigned     NCH     = NBIT + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

    logic [NCH-1:0]   w_raw;
    logic [NCH-1:0]   r_s1;
    logic [NCH-1:0]   r_s2;
    logic [NCH-1:0]   r_h;
    logic [NCH-1:0]   w_upd;
    logic [CNT_W-1:0] r_cnt [NCH];

    // Enable rides as the top channel so every channel is handled uniformly.
    assign w_raw = {en_in, sw_in};

    // Two-flop synchroniser, nothing between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // A channel accepts its new level on the edge that completes the run.
    always_comb begin
        w_upd = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_upd[i] = (r_s2[i] != r_h[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    // Stability counters and held values; any match restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (r_s2[i] == r_h[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_upd[i]) begin
                    r_h[i]   <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign x_out  = r_h[NBIT-1:0];
    assign en_out = r_h[NBIT];

`ifdef SWDB_CHG_PULSE_EN
    logic r_chg;

    // Registered alongside r_h so the strobe lines up with the new outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chg <= 1'b0;
        end else begin
            r_chg <= |w_upd;
        end
    end

    assign chg = r_chg;
`else
    assign chg = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce8.sv
// Testbench for sw_debounce8. The reference model keeps a history of applied
// input vectors and accepts a bit once the synchronised samples in the last
// STABLE_CYC edges all differ from the held value.

module tb_sw_debounce8;

    localparam int unsigned NBIT  = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned S     = 4;

`ifdef SWDB_CHG_PULSE_EN
    localparam bit CHG_ON = 1'b1;
`else
    localparam bit CHG_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NBIT-1:0] sw_in = '0;
    logic            en_in = 1'b0;
    logic [NBIT-1:0] x_out;
    logic            en_out;
    logic            chg;

    int errors = 0;
    int checks = 0;

    logic [NBIT:0] hist [$];
    logic [NBIT:0] m_h;
    logic          m_chg;

    sw_debounce8 #(.NBIT(NBIT), .CNT_W(CNT_W), .STABLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .en_in(en_in),
        .x_out(x_out), .en_out(en_out), .chg(chg)
    );

    always #5 clk = ~clk;

    // Reset leaves the synchroniser and held values at zero.
    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < int'(S) + 2; i++) hist.push_front('0);
        m_h   = '0;
        m_chg = 1'b0;
    endtask

    // Update the model for the coming edge, then advance to 1 ns after that edge.
    task automatic step();
        logic [NBIT:0] mask;
        hist.push_front({en_in, sw_in});
        mask = '1;
        // Edge k sees the input applied at edge k-2 in the second flop.
        for (int j = 2; j < int'(S) + 2; j++) mask &= hist[j] ^ m_h;
        m_h   = m_h ^ mask;
        m_chg = (|mask) & CHG_ON;
        while (hist.size() > S + 2) void'(hist.pop_back());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        sw_in = 8'hFF;
        en_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (x_out !== 8'h00 || en_out !== 1'b0 || chg !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: x=%h en=%b chg=%b expected 00/0/0", x_out, en_out, chg);
            end
        end
        model_clear();
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (x_out !== m_h[NBIT-1:0] || en_out !== m_h[NBIT] || chg !== m_chg) begin
                errors++;
                $display("FAIL reset_release e%0d: x=%h en=%b chg=%b expected %h/%b/%b",
                         e, x_out, en_out, chg, m_h[NBIT-1:0], m_h[NBIT], m_chg);
            end
            if (e == 5 || e == 6) begin
                checks++;
                if (x_out !== ((e == 6) ? 8'hFF : 8'h00) || en_out !== (e == 6)) begin
                    errors++;
                    $display("FAIL reset_latency e%0d: x=%h en=%b", e, x_out, en_out);
                end
            end
        end
    endtask

    task automatic test_clean_step();
        int first_edge;
        int nchg;
        sw_in = 8'h00;
        for (int e = 0; e < 8; e++) step();
        checks++;
        if (x_out !== 8'h00) begin
            errors++;
            $display("FAIL clean_pre: x=%h expected 00", x_out);
        end
        sw_in      = 8'h80;
        first_edge = 0;
        nchg       = 0;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (chg === 1'b1) nchg++;
            if (first_edge == 0 && x_out === 8'h80) first_edge = e;
            checks++;
            if (x_out !== m_h[NBIT-1:0] || chg !== m_chg) begin
                errors++;
                $display("FAIL clean_step e%0d: x=%h chg=%b expected %h/%b",
                         e, x_out, chg, m_h[NBIT-1:0], m_chg);
            end
        end
        checks++;
        if (first_edge != 6) begin
            errors++;
            $display("FAIL clean_latency: edge=%0d expected 6", first_edge);
        end
        checks++;
        if (nchg != int'(CHG_ON)) begin
            errors++;
            $display("FAIL clean_chg_count: %0d expected %0d", nchg, int'(CHG_ON));
        end
    endtask

    task automatic test_bounce();
        int  lens [5] = '{3, 1, 3, 6, 0};
        bit  lvls [5] = '{1, 0, 1, 0, 0};
        int  first_edge;
        for (int p = 0; p < 4; p++) begin
            sw_in[3] = lvls[p];
            for (int e = 0; e < lens[p]; e++) begin
                step();
                checks++;
                if (x_out[3] !== 1'b0 || chg !== 1'b0 || x_out !== m_h[NBIT-1:0]) begin
                    errors++;
                    $display("FAIL bounce_reject: x=%h chg=%b expected %h/0", x_out, chg, m_h[NBIT-1:0]);
                end
            end
        end
        sw_in[3]   = 1'b1;
        first_edge = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (first_edge == 0 && x_out[3] === 1'b1) first_edge = e;
            checks++;
            if (x_out !== m_h[NBIT-1:0] || chg !== m_chg) begin
                errors++;
                $display("FAIL bounce_stable e%0d: x=%h chg=%b expected %h/%b",
                         e, x_out, chg, m_h[NBIT-1:0], m_chg);
            end
        end
        checks++;
        if (first_edge != 6) begin
            errors++;
            $display("FAIL bounce_latency: edge=%0d expected 6", first_edge);
        end
    endtask

    task automatic test_simultaneous();
        int nchg;
        int ex;
        int een;
        sw_in = 8'h00;
        en_in = 1'b0;
        for (int e = 0; e < 8; e++) step();
        sw_in = 8'h81;
        en_in = 1'b1;
        nchg  = 0;
        ex    = 0;
        een   = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (chg === 1'b1) nchg++;
            if (ex == 0 && x_out === 8'h81) ex = e;
            if (een == 0 && en_out === 1'b1) een = e;
            checks++;
            if (x_out !== m_h[NBIT-1:0] || en_out !== m_h[NBIT] || chg !== m_chg) begin
                errors++;
                $display("FAIL simul e%0d: x=%h en=%b chg=%b expected %h/%b/%b",
                         e, x_out, en_out, chg, m_h[NBIT-1:0], m_h[NBIT], m_chg);
            end
        end
        checks++;
        if (ex != 6 || een != 6 || nchg != int'(CHG_ON)) begin
            errors++;
            $display("FAIL simul_edges: x_edge=%0d en_edge=%0d chg_cycles=%0d expected 6/6/%0d",
                     ex, een, nchg, int'(CHG_ON));
        end
    endtask

    task automatic test_reset_midcount();
        sw_in = 8'h00;
        en_in = 1'b0;
        for (int e = 0; e < 8; e++) step();
        sw_in = 8'h01;
        for (int e = 0; e < 4; e++) step();
        rst = 1'b1;
        #1;
        checks++;
        if (x_out !== 8'h00 || en_out !== 1'b0 || chg !== 1'b0) begin
            errors++;
            $display("FAIL midcount_rst: x=%h en=%b chg=%b expected 00/0/0", x_out, en_out, chg);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (x_out !== ((e >= 6) ? 8'h01 : 8'h00) || x_out !== m_h[NBIT-1:0] || chg !== m_chg) begin
                errors++;
                $display("FAIL midcount e%0d: x=%h chg=%b expected %h/%b",
                         e, x_out, chg, m_h[NBIT-1:0], m_chg);
            end
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 11) == 0) begin
                rst = 1'b1;
                #1;
                checks++;
                if (x_out !== 8'h00 || en_out !== 1'b0 || chg !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_rst: x=%h en=%b chg=%b expected 00/0/0", x_out, en_out, chg);
                end
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_clear();
            end
            sw_in = NBIT'($urandom);
            en_in = 1'($urandom);
            for (int e = 0; e < int'($urandom_range(1, 7)); e++) begin
                step();
                checks++;
                if (x_out !== m_h[NBIT-1:0] || en_out !== m_h[NBIT] || chg !== m_chg) begin
                    errors++;
                    $display("FAIL random seg%0d: x=%h en=%b chg=%b expected %h/%b/%b",
                             seg, x_out, en_out, chg, m_h[NBIT-1:0], m_h[NBIT], m_chg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_simultaneous();
        test_reset_midcount();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
